ps2_host_tx: RTL and testbench

//  Host-to-device PS/2 transmitter. Sends one command byte (LED set, reset, scan-set) to the keyboard over the same

---
 rtl/ps2_host_tx_pkg.sv | 26 ++
 rtl/ps2_line_filter.sv | 46 ++++
 rtl/ps2_host_tx.sv | 204 ++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_host_tx_pkg.sv
// PS/2 host transmitter shared definitions: command bytes and frame layout.
package ps2_host_tx_pkg;

    localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] PS2_CMD_ECHO     = 8'hEE;
    localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;

    // Data bits, parity and stop; the start bit is the held-low data line itself.
    localparam int unsigned PS2_FRAME_BITS = 10;

    typedef struct packed {
        logic       stop;
        logic       parity;
        logic [7:0] data;
    } ps2_frame_t;

    // Build the shifted-out frame: odd parity over the byte, stop bit released high.
    function automatic ps2_frame_t ps2_make_frame(input logic [7:0] data);
        ps2_frame_t f;
        f.stop   = 1'b1;
        f.parity = ~^data;
        f.data   = data;
        return f;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Synchroniser plus stability filter for one raw PS/2 line, with a falling-edge strobe.
module ps2_line_filter #(
    parameter int unsigned FILTER_LEN = 8
) (
    input  logic clk28,
    input  logic rst_n,
    input  logic line_in,
    output logic level,
    output logic fall
);

    localparam int unsigned CNT_W = $clog2(FILTER_LEN + 1);

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] stable_cnt;

    // Two-flop synchroniser; idle line is high.
    always_ff @(posedge clk28) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], line_in};
        end
    end

    // Accept a new level only after FILTER_LEN consecutive differing samples.
    always_ff @(posedge clk28) begin
        if (!rst_n) begin
            stable_cnt <= '0;
            level      <= 1'b1;
            fall       <= 1'b0;
        end else begin
            fall <= 1'b0;
            if (sync_q[1] == level) begin
                stable_cnt <= '0;
            end else if (stable_cnt == CNT_W'(FILTER_LEN - 1)) begin
                level      <= sync_q[1];
                stable_cnt <= '0;
                fall       <= level;
            end else begin
                stable_cnt <= stable_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, clock out one frame, check the ack.
module ps2_host_tx
    import ps2_host_tx_pkg::*;
#(
    parameter int unsigned CLK_FREQ         = 28_000_000,
    parameter int unsigned INHIBIT_US       = 100,
    parameter int unsigned START_TIMEOUT_MS = 15,
    parameter int unsigned XFER_TIMEOUT_MS  = 2,
    parameter int unsigned FILTER_LEN       = 8
) (
    input  logic       clk28,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_error,
    output logic       busy,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe
);

    localparam int unsigned INHIBIT_CYC = CLK_FREQ / 1_000_000 * INHIBIT_US;
    localparam int unsigned START_CYC   = CLK_FREQ / 1_000 * START_TIMEOUT_MS;
    localparam int unsigned XFER_CYC    = CLK_FREQ / 1_000 * XFER_TIMEOUT_MS;
    localparam int unsigned MAX_CYC     = (START_CYC > XFER_CYC)
                                        ? ((START_CYC > INHIBIT_CYC) ? START_CYC : INHIBIT_CYC)
                                        : ((XFER_CYC > INHIBIT_CYC) ? XFER_CYC : INHIBIT_CYC);
    localparam int unsigned TIMER_W     = $clog2(MAX_CYC);
    localparam int unsigned BITCNT_W    = 4;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        START,
        WAIT_CLK,
        XFER,
        ACK,
        RECOVER
    } state_t;

    state_t                    state_q, state_d;
    logic [TIMER_W-1:0]        timer_q, timer_d;
    logic [BITCNT_W-1:0]       bitcnt_q, bitcnt_d;
    logic [PS2_FRAME_BITS-1:0] shreg_q, shreg_d;
    logic                      clk_oe_d, dat_oe_d;
    logic                      done_d, abort, ready_d, busy_d;
    logic                      xfer_expired;

    logic clk_level, clk_fall;
    logic dat_level, dat_fall_unused;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk28   (clk28),
        .rst_n   (rst_n),
        .line_in (ps2_clk_in),
        .level   (clk_level),
        .fall    (clk_fall)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filter (
        .clk28   (clk28),
        .rst_n   (rst_n),
        .line_in (ps2_dat_in),
        .level   (dat_level),
        .fall    (dat_fall_unused)
    );

    assign xfer_expired = (timer_q == TIMER_W'(XFER_CYC - 1));

    // Next-state and registered-output decode.
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        bitcnt_d = bitcnt_q;
        shreg_d  = shreg_q;
        clk_oe_d = ps2_clk_oe;
        dat_oe_d = ps2_dat_oe;
        done_d   = 1'b0;
        abort    = 1'b0;

        case (state_q)
            IDLE: begin
                if (tx_valid && tx_ready) begin
                    shreg_d  = ps2_make_frame(tx_data);
                    timer_d  = '0;
                    bitcnt_d = '0;
                    clk_oe_d = 1'b1;
                    dat_oe_d = 1'b0;
                    state_d  = INHIBIT;
                end
            end
            INHIBIT: begin
                // One cycle of the hold is spent in START, so leave a cycle early.
                if (timer_q == TIMER_W'(INHIBIT_CYC - 2)) begin
                    timer_d  = '0;
                    dat_oe_d = 1'b1;
                    state_d  = START;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            START: begin
                clk_oe_d = 1'b0;
                timer_d  = '0;
                state_d  = WAIT_CLK;
            end
            WAIT_CLK: begin
                if (clk_fall) begin
                    timer_d  = '0;
                    dat_oe_d = ~shreg_q[0];
                    bitcnt_d = BITCNT_W'(1);
                    state_d  = XFER;
                end else if (timer_q == TIMER_W'(START_CYC - 1)) begin
                    abort = 1'b1;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            XFER: begin
                if (xfer_expired) begin
                    abort = 1'b1;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                    if (clk_fall) begin
                        dat_oe_d = ~shreg_q[bitcnt_q];
                        bitcnt_d = bitcnt_q + BITCNT_W'(1);
                        if (bitcnt_q == BITCNT_W'(PS2_FRAME_BITS - 1)) begin
                            state_d = ACK;
                        end
                    end
                end
            end
            ACK: begin
                if (xfer_expired) begin
                    abort = 1'b1;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                    if (clk_fall) begin
                        if (!dat_level) begin
                            state_d = RECOVER;
                        end else begin
                            abort = 1'b1;
                        end
                    end
                end
            end
            RECOVER: begin
                if (xfer_expired) begin
                    abort = 1'b1;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                    if (clk_level && dat_level) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (abort) begin
            clk_oe_d = 1'b0;
            dat_oe_d = 1'b0;
            state_d  = IDLE;
        end

        // Ready only once IDLE has been held for a cycle, i.e. after the done/error pulse.
        ready_d = (state_d == IDLE) && (state_q == IDLE);
        busy_d  = (state_d != IDLE);
    end

    // State and output registers; reset releases both lines immediately.
    always_ff @(posedge clk28) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            bitcnt_q   <= '0;
            shreg_q    <= '0;
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
            tx_done    <= 1'b0;
            tx_error   <= 1'b0;
            tx_ready   <= 1'b1;
            busy       <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            bitcnt_q   <= bitcnt_d;
            shreg_q    <= shreg_d;
            ps2_clk_oe <= clk_oe_d;
            ps2_dat_oe <= dat_oe_d;
            tx_done    <= done_d;
            tx_error   <= abort;
            tx_ready   <= ready_d;
            busy       <= busy_d;
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model clocks frames out of the host and checks them.
module tb_ps2_host_tx;
    import ps2_host_tx_pkg::*;

    localparam int HALF        = 40;      // 12.5 kHz device clock at 1 MHz system clock
    localparam int INHIBIT_CYC = 100;     // 100 us at 1 MHz
    localparam int START_CYC   = 15_000;  // 15 ms at 1 MHz

    logic       clk28 = 1'b0;
    logic       rst_n;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready, tx_done, tx_error, busy;
    logic       ps2_clk_oe, ps2_dat_oe;
    logic       bfm_clk_low, bfm_dat_low;
    logic       clk_line, dat_line;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc = 0, hold_run = 0, last_hold = 0, rel_cyc = 0, err_cyc = 0;
    int done_cnt = 0, err_cnt = 0, both_cnt = 0, fall11_cyc = 0;
    logic prev_clk_oe = 1'b0;

    // Open-drain wired-AND of host and device pull-downs.
    assign clk_line = ~ps2_clk_oe & ~bfm_clk_low;
    assign dat_line = ~ps2_dat_oe & ~bfm_dat_low;

    always #5 clk28 = ~clk28;

    ps2_host_tx #(
        .CLK_FREQ         (1_000_000),
        .INHIBIT_US       (100),
        .START_TIMEOUT_MS (15),
        .XFER_TIMEOUT_MS  (2),
        .FILTER_LEN       (8)
    ) dut (
        .clk28      (clk28),
        .rst_n      (rst_n),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_done    (tx_done),
        .tx_error   (tx_error),
        .busy       (busy),
        .ps2_clk_in (clk_line),
        .ps2_dat_in (dat_line),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_dat_oe (ps2_dat_oe)
    );

    // Pulse counters, inhibit length and clock-release timestamps.
    always @(negedge clk28) begin
        cyc         <= cyc + 1;
        prev_clk_oe <= ps2_clk_oe;
        if (ps2_clk_oe) begin
            hold_run <= hold_run + 1;
        end else if (prev_clk_oe) begin
            last_hold <= hold_run;
            hold_run  <= 0;
            rel_cyc   <= cyc;
        end
        if (tx_done) done_cnt <= done_cnt + 1;
        if (tx_error) begin
            err_cnt <= err_cnt + 1;
            err_cyc <= cyc;
        end
        if (tx_done && tx_error) both_cnt <= both_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic send_byte(input logic [7:0] data, input string tag);
        bit rdy;
        rdy = 1'b0;
        for (int i = 0; i < 1000 && !rdy; i++) begin
            @(negedge clk28);
            rdy = tx_ready;
        end
        check({tag, "_ready"}, 32'(rdy), 32'(1));
        tx_data  = data;
        tx_valid = 1'b1;
        @(negedge clk28);
        tx_valid = 1'b0;
    endtask

    // Device side: wait for request-to-send, generate 11 clocks, sample on rising edges, ack on the 11th.
    task automatic device_xfer(input bit do_ack, input int glitch_bit, input int poke_bit,
                               input int reset_bit, output logic [9:0] rx, output bit got_req,
                               output bit start_ok, output bit aborted);
        rx       = '0;
        got_req  = 1'b0;
        start_ok = 1'b0;
        aborted  = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk28);
            if (clk_line && !dat_line) begin
                got_req = 1'b1;
                break;
            end
        end
        if (!got_req) return;
        repeat ($urandom_range(10, 100)) @(negedge clk28);
        start_ok = !dat_line;
        for (int k = 1; k <= 11; k++) begin
            bfm_clk_low = 1'b1;
            if (k == 11) fall11_cyc = cyc;
            repeat (HALF) @(negedge clk28);
            bfm_clk_low = 1'b0;
            if (k <= 10) rx[4'(k - 1)] = dat_line;
            if (k == 11) bfm_dat_low = 1'b0;
            for (int c = 0; c < HALF; c++) begin
                @(negedge clk28);
                if (k == 10 && do_ack && c == 5) bfm_dat_low = 1'b1;
                if (k == glitch_bit && c == 10) bfm_clk_low = 1'b1;
                if (k == glitch_bit && c == 13) bfm_clk_low = 1'b0;
                if (k == poke_bit && c == 20) begin
                    check("busy_ready_low", 32'(tx_ready), 32'(0));
                    check("busy_flag", 32'(busy), 32'(1));
                    tx_data  = 8'h5A;
                    tx_valid = 1'b1;
                end
                if (k == poke_bit && c == 21) tx_valid = 1'b0;
                if (k == reset_bit && c == 10) rst_n = 1'b0;
                if (k == reset_bit && c == 11) begin
                    check("midrst_clk_oe", 32'(ps2_clk_oe), 32'(0));
                    check("midrst_dat_oe", 32'(ps2_dat_oe), 32'(0));
                    check("midrst_busy", 32'(busy), 32'(0));
                    check("midrst_ready", 32'(tx_ready), 32'(1));
                    rst_n       = 1'b1;
                    bfm_clk_low = 1'b0;
                    bfm_dat_low = 1'b0;
                    aborted     = 1'b1;
                    return;
                end
            end
        end
    endtask

    // One host transmission against the device model, checked against the frame rules.
    task automatic run_xfer(input logic [7:0] data, input bit do_ack, input int glitch_bit,
                            input int poke_bit, input int reset_bit, input string tag);
        int         d0, e0, lat;
        logic [9:0] rx;
        bit         got_req, start_ok, aborted, fin;
        logic       exp_par;
        d0 = done_cnt;
        e0 = err_cnt;
        send_byte(data, tag);
        device_xfer(do_ack, glitch_bit, poke_bit, reset_bit, rx, got_req, start_ok, aborted);
        check({tag, "_req"}, 32'(got_req), 32'(1));
        if (aborted) begin
            repeat (300) @(negedge clk28);
            check({tag, "_abort_done"}, done_cnt - d0, 0);
            check({tag, "_abort_err"}, err_cnt - e0, 0);
            return;
        end
        fin = 1'b0;
        for (int i = 0; i < 500 && !fin; i++) begin
            @(negedge clk28);
            fin = (done_cnt != d0) || (err_cnt != e0);
        end
        repeat (4) @(negedge clk28);
        exp_par = ($countones(data) % 2) == 0;
        check({tag, "_start"}, 32'(start_ok), 32'(1));
        check({tag, "_data"}, 32'(rx[7:0]), 32'(data));
        check({tag, "_parity"}, 32'(rx[8]), 32'(exp_par));
        check({tag, "_stop"}, 32'(rx[9]), 32'(1));
        check({tag, "_done_pulses"}, done_cnt - d0, do_ack ? 1 : 0);
        check({tag, "_err_pulses"}, err_cnt - e0, do_ack ? 0 : 1);
        check({tag, "_inhibit_len"},
              32'(last_hold >= INHIBIT_CYC - 1 && last_hold <= INHIBIT_CYC + 1), 32'(1));
        check({tag, "_ready_after"}, 32'(tx_ready), 32'(1));
        check({tag, "_lines_released"}, 32'({ps2_clk_oe, ps2_dat_oe}), 32'(0));
        if (!do_ack) begin
            lat = err_cyc - fall11_cyc;
            check({tag, "_err_at_11th_edge"}, 32'(lat >= 0 && lat <= 25), 32'(1));
        end
    endtask

    // Bound the whole run.
    initial begin
        repeat (90_000) @(negedge clk28);
        $display("FAIL watchdog: cycle budget exhausted, got %0d checks expected completion", n_checks);
        $fatal(1, "bench timeout");
    end

    initial begin
        int         d0, e0, lat;
        bit         fin;
        logic [7:0] rb;
        rst_n       = 1'b0;
        tx_valid    = 1'b0;
        tx_data     = 8'h00;
        bfm_clk_low = 1'b0;
        bfm_dat_low = 1'b0;
        repeat (3) @(negedge clk28);
        check("rst_ready", 32'(tx_ready), 32'(1));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(tx_done), 32'(0));
        check("rst_error", 32'(tx_error), 32'(0));
        check("rst_clk_oe", 32'(ps2_clk_oe), 32'(0));
        check("rst_dat_oe", 32'(ps2_dat_oe), 32'(0));
        rst_n = 1'b1;
        repeat (5) @(negedge clk28);

        run_xfer(PS2_CMD_SET_LEDS, 1'b1, 0, 0, 0, "t1_leds");
        run_xfer(8'h00, 1'b1, 0, 0, 0, "t2_zero");
        run_xfer(8'h01, 1'b1, 0, 0, 0, "t2_one");

        // Device never clocks: start timeout.
        d0 = done_cnt;
        e0 = err_cnt;
        send_byte(8'hF4, "t3");
        fin = 1'b0;
        for (int i = 0; i < START_CYC + 1000 && !fin; i++) begin
            @(negedge clk28);
            fin = (err_cnt != e0);
        end
        repeat (3) @(negedge clk28);
        check("t3_err_pulses", err_cnt - e0, 1);
        check("t3_done_pulses", done_cnt - d0, 0);
        lat = err_cyc - rel_cyc;
        check("t3_timeout_cycles", 32'(lat >= START_CYC - 2 && lat <= START_CYC + 2), 32'(1));
        check("t3_ready", 32'(tx_ready), 32'(1));
        check("t3_lines_released", 32'({ps2_clk_oe, ps2_dat_oe}), 32'(0));

        run_xfer(8'($urandom), 1'b0, 0, 0, 0, "t4_noack");

        run_xfer(8'($urandom), 1'b1, 0, 0, 4, "t5_reset");
        run_xfer(PS2_CMD_RESET, 1'b1, 0, 0, 0, "t5_after");

        run_xfer(8'($urandom), 1'b1, 3, 6, 0, "t6_glitch_poke");

        for (int i = 0; i < 4; i++) begin
            rb = (i == 0) ? PS2_CMD_ECHO : 8'($urandom);
            run_xfer(rb, 1'b1, 0, 0, 0, "rand");
        end

        check("done_err_exclusive", both_cnt, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
